rr_grant_ctrl: RTL and testbench

RR_GRANT_CTRL -- requirements
Module: rr_grant_ctrl

---
 rtl/rr_grant_ctrl_if.sv | 33 +++
 rtl/rr_grant_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_rr_grant_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/rr_grant_ctrl_if.sv
// Request/grant bundle between a set of requesters and the round-robin grant controller.
// The master side drives requests and releases; the slave side returns the registered grant.
interface rr_grant_ctrl_if #(
    parameter int unsigned WIDTH = 10
) ();
    logic [WIDTH-1:0] req;
    logic             done;
    logic [WIDTH-1:0] grant;
    logic             grant_valid;
    logic [3:0]       grant_id;
    logic             timeout;
    logic             error;

    modport master (
        output req,
        output done,
        input  grant,
        input  grant_valid,
        input  grant_id,
        input  timeout,
        input  error
    );

    modport slave (
        input  req,
        input  done,
        output grant,
        output grant_valid,
        output grant_id,
        output timeout,
        output error
    );
endinterface

// File: rtl/rr_grant_ctrl.sv
// Round-robin grant controller: one grantee at a time, released by done, requester drop or hold limit.
// All outputs are registered; one idle turnaround cycle separates consecutive grants.
module rr_grant_ctrl #(
    parameter int unsigned WIDTH    = 10,
    parameter int unsigned HOLD_MAX = 16
) (
    input logic            clock,
    input logic            reset_n,
    rr_grant_ctrl_if.slave bus
);

    localparam int unsigned ID_W    = 4;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned REQ_PAD = 16;
    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);
    localparam bit HOLD_EN = (HOLD_MAX != 0);
    localparam logic [ID_W-1:0] PTR_RST = ID_W'(WIDTH - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [ID_W-1:0]  ptr_q;
    logic [ID_W-1:0]  ptr_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [WIDTH-1:0] grant_q;
    logic [WIDTH-1:0] grant_d;
    logic             grant_valid_q;
    logic             grant_valid_d;
    logic [ID_W-1:0]  grant_id_q;
    logic [ID_W-1:0]  grant_id_d;
    logic             timeout_q;
    logic             timeout_d;
    logic             error_q;
    logic             error_d;

    logic [REQ_PAD-1:0] req_pad;
    logic [ID_W-1:0]    cand;
    logic [ID_W-1:0]    win_idx;
    logic               win_found;
    logic [WIDTH-1:0]   win_onehot;
    logic               cur_req;
    logic               hold_hit;
    logic               grant_exit;
    logic               grant_multi;

    // Zero-padded request vector so any 4-bit index is in range.
    assign req_pad    = REQ_PAD'(bus.req);
    assign win_onehot = WIDTH'(1) << win_idx;

    assign cur_req     = req_pad[grant_id_q];
    assign hold_hit    = HOLD_EN && (count_q == HOLD_LIM);
    assign grant_exit  = bus.done || !cur_req || hold_hit;
    assign grant_multi = (grant_q & (grant_q - WIDTH'(1))) != '0;

    // Search ptr+1, ptr+2, ... wrapping, with ptr itself examined last.
    always_comb begin : rr_search
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= WIDTH; k++) begin
            cand = ID_W'((32'(ptr_q) + k) % WIDTH);
            if (!win_found && req_pad[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // State register.
    always_ff @(posedge clock) begin : state_reg
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin : next_state
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (grant_exit) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath state.
    always_comb begin : output_logic
        ptr_d         = ptr_q;
        count_d       = count_q;
        grant_d       = grant_q;
        grant_valid_d = grant_valid_q;
        grant_id_d    = grant_id_q;
        timeout_d     = 1'b0;
        error_d       = error_q
                        | ((state_q == IDLE) && bus.done)
                        | (grant_valid_q && grant_multi);
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    grant_d       = win_onehot;
                    grant_valid_d = 1'b1;
                    grant_id_d    = win_idx;
                    ptr_d         = win_idx;
                    count_d       = CNT_W'(1);
                end else begin
                    grant_d       = '0;
                    grant_valid_d = 1'b0;
                    grant_id_d    = '0;
                    count_d       = '0;
                end
            end
            GRANT: begin
                if (grant_exit) begin
                    grant_d       = '0;
                    grant_valid_d = 1'b0;
                    grant_id_d    = '0;
                    count_d       = '0;
                    // done wins over a simultaneous hold expiry.
                    timeout_d     = hold_hit && !bus.done;
                end else if (count_q != '1) begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            default: begin
                grant_d       = '0;
                grant_valid_d = 1'b0;
                grant_id_d    = '0;
                count_d       = '0;
            end
        endcase
    end

    // Output and datapath registers.
    always_ff @(posedge clock) begin : data_reg
        if (!reset_n) begin
            ptr_q         <= PTR_RST;
            count_q       <= '0;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
            timeout_q     <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            ptr_q         <= ptr_d;
            count_q       <= count_d;
            grant_q       <= grant_d;
            grant_valid_q <= grant_valid_d;
            grant_id_q    <= grant_id_d;
            timeout_q     <= timeout_d;
            error_q       <= error_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_valid = grant_valid_q;
    assign bus.grant_id    = grant_id_q;
    assign bus.timeout     = timeout_q;
    assign bus.error       = error_q;

    // Structural invariants of the registered grant.
    a_valid_matches : assert property (@(posedge clock) disable iff (!reset_n)
        grant_valid_q == (grant_q != '0));
    a_id_matches : assert property (@(posedge clock) disable iff (!reset_n)
        grant_valid_q |-> (grant_q == win_onehot_of(grant_id_q)));
    a_timeout_idle : assert property (@(posedge clock) disable iff (!reset_n)
        timeout_q |-> !grant_valid_q);

    function automatic logic [WIDTH-1:0] win_onehot_of(input logic [ID_W-1:0] idx);
        return WIDTH'(1) << idx;
    endfunction

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// Directed bench for rr_grant_ctrl: vector table plus hand-written multi-cycle sequences.
// dut uses the default hold limit (16); dut_h4 shares the stimulus with a hold limit of 4.
module tb_rr_grant_ctrl;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [9:0] req = '0;
    logic       done = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    rr_grant_ctrl_if #(.WIDTH(10)) bus_d ();
    rr_grant_ctrl_if #(.WIDTH(10)) bus_h ();

    assign bus_d.req  = req;
    assign bus_d.done = done;
    assign bus_h.req  = req;
    assign bus_h.done = done;

    rr_grant_ctrl #(.WIDTH(10), .HOLD_MAX(16)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus_d)
    );

    rr_grant_ctrl #(.WIDTH(10), .HOLD_MAX(4)) dut_h4 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus_h)
    );

    typedef struct {
        logic       rst_n;
        logic [9:0] req;
        logic       done;
        logic [9:0] grant;
        logic       valid;
        logic [3:0] id;
        logic       timeout;
        logic       error;
    } vec_t;

    localparam int NVEC = 19;
    vec_t vecs[NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Compare every output of one instance against expected values.
    task automatic chk_bus(input string tag, input bit use_h, input logic [9:0] g,
                           input logic v, input logic [3:0] id, input logic to,
                           input logic er);
        if (use_h) begin
            chk({tag, " grant"},   32'(bus_h.grant),       32'(g));
            chk({tag, " valid"},   32'(bus_h.grant_valid), 32'(v));
            chk({tag, " id"},      32'(bus_h.grant_id),    32'(id));
            chk({tag, " timeout"}, 32'(bus_h.timeout),     32'(to));
            chk({tag, " error"},   32'(bus_h.error),       32'(er));
        end else begin
            chk({tag, " grant"},   32'(bus_d.grant),       32'(g));
            chk({tag, " valid"},   32'(bus_d.grant_valid), 32'(v));
            chk({tag, " id"},      32'(bus_d.grant_id),    32'(id));
            chk({tag, " timeout"}, 32'(bus_d.timeout),     32'(to));
            chk({tag, " error"},   32'(bus_d.error),       32'(er));
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req     = '0;
        done    = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        // rst_n, req, done -> grant, valid, id, timeout, error (sampled after the edge)
        vecs[0]  = '{1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 4'd0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 10'h001, 1'b0, 10'h001, 1'b1, 4'd0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 10'h001, 1'b0, 10'h001, 1'b1, 4'd0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 10'h000, 1'b0, 10'h000, 1'b0, 4'd0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 10'h000, 1'b0, 10'h000, 1'b0, 4'd0, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 10'h3FF, 1'b0, 10'h002, 1'b1, 4'd1, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 10'h3FF, 1'b0, 10'h002, 1'b1, 4'd1, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 10'h3FF, 1'b1, 10'h000, 1'b0, 4'd0, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 10'h3FF, 1'b0, 10'h004, 1'b1, 4'd2, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 10'h3FF, 1'b1, 10'h000, 1'b0, 4'd0, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 10'h3FF, 1'b0, 10'h008, 1'b1, 4'd3, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 10'h3FF, 1'b1, 10'h000, 1'b0, 4'd0, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 10'h200, 1'b0, 10'h200, 1'b1, 4'd9, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 10'h201, 1'b1, 10'h000, 1'b0, 4'd0, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 10'h201, 1'b0, 10'h001, 1'b1, 4'd0, 1'b0, 1'b0};
        vecs[15] = '{1'b1, 10'h001, 1'b1, 10'h000, 1'b0, 4'd0, 1'b0, 1'b0};
        vecs[16] = '{1'b1, 10'h000, 1'b1, 10'h000, 1'b0, 4'd0, 1'b0, 1'b1};
        vecs[17] = '{1'b1, 10'h000, 1'b0, 10'h000, 1'b0, 4'd0, 1'b0, 1'b1};
        vecs[18] = '{1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 4'd0, 1'b0, 1'b0};

        #1;
        for (int i = 0; i < NVEC; i++) begin
            reset_n = vecs[i].rst_n;
            req     = vecs[i].req;
            done    = vecs[i].done;
            tick();
            chk_bus($sformatf("vec%0d", i), 1'b0, vecs[i].grant, vecs[i].valid,
                    vecs[i].id, vecs[i].timeout, vecs[i].error);
        end

        // Full rotation 0..9 then back to 0, done in the second grant cycle.
        do_reset();
        req = 10'h3FF;
        for (int i = 0; i <= 10; i++) begin
            logic [9:0] e;
            e = 10'(1) << (i % 10);
            done = 1'b0;
            tick();
            chk_bus($sformatf("rot%0d c1", i), 1'b0, e, 1'b1, 4'(i % 10), 1'b0, 1'b0);
            tick();
            chk_bus($sformatf("rot%0d c2", i), 1'b0, e, 1'b1, 4'(i % 10), 1'b0, 1'b0);
            done = 1'b1;
            tick();
            chk_bus($sformatf("rot%0d gap", i), 1'b0, 10'h000, 1'b0, 4'd0, 1'b0, 1'b0);
        end
        done = 1'b0;

        // Hold limit 4: four grant cycles, one timeout idle cycle, then re-grant.
        do_reset();
        req = 10'h008;
        for (int c = 1; c <= 4; c++) begin
            tick();
            chk_bus($sformatf("hold4 c%0d", c), 1'b1, 10'h008, 1'b1, 4'd3, 1'b0, 1'b0);
        end
        tick();
        chk_bus("hold4 expire", 1'b1, 10'h000, 1'b0, 4'd0, 1'b1, 1'b0);
        chk_bus("hold16 still", 1'b0, 10'h008, 1'b1, 4'd3, 1'b0, 1'b0);
        tick();
        chk_bus("hold4 regrant", 1'b1, 10'h008, 1'b1, 4'd3, 1'b0, 1'b0);

        // done coinciding with hold expiry counts as done.
        do_reset();
        req = 10'h008;
        for (int c = 1; c <= 4; c++) tick();
        chk_bus("both c4", 1'b1, 10'h008, 1'b1, 4'd3, 1'b0, 1'b0);
        done = 1'b1;
        tick();
        chk_bus("both exit", 1'b1, 10'h000, 1'b0, 4'd0, 1'b0, 1'b0);
        done = 1'b0;

        // Default limit of 16 cycles.
        do_reset();
        req = 10'h008;
        for (int c = 1; c <= 16; c++) begin
            tick();
            chk(($sformatf("hold16 c%0d grant", c)), 32'(bus_d.grant), 32'(10'h008));
        end
        tick();
        chk_bus("hold16 expire", 1'b0, 10'h000, 1'b0, 4'd0, 1'b1, 1'b0);

        // Reset in the middle of a grant to id 5 restores requester 0 priority.
        do_reset();
        req = 10'h020;
        tick();
        chk_bus("mid g5", 1'b0, 10'h020, 1'b1, 4'd5, 1'b0, 1'b0);
        reset_n = 1'b0;
        tick();
        chk_bus("mid rst", 1'b0, 10'h000, 1'b0, 4'd0, 1'b0, 1'b0);
        reset_n = 1'b1;
        req = 10'h3FF;
        tick();
        chk_bus("mid after", 1'b0, 10'h001, 1'b1, 4'd0, 1'b0, 1'b0);
        tick();
        chk_bus("mid no to", 1'b0, 10'h001, 1'b1, 4'd0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
